uart_tx_rx_massiv: RTL and testbench



---
 rtl/uart_massiv_pkg.sv | 32 +++
 rtl/uart_rx_frame.sv | 129 ++++++++++++
 rtl/uart_tx_rx_massiv.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_tx_rx_massiv.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_massiv_pkg.sv
// Shared definitions for the packet-array UART: parity codes, bit-period helper, FSM state types.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_massiv_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per serial bit; the ratio must be an integer of at least 2.
  function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_frame.sv
// Single-frame UART receiver: start detect, mid-bit sampling, parity/stop check.
// Latency: data/vld/err strobe one cycle after the mid-sample of the last stop bit.
// Backpressure: none; the strobe is a one-cycle pulse the consumer must take.
// Ports: clk/rst (sync, active-high), rx_line serial input,
//        frame_dat received pack, frame_vld good frame strobe, frame_err bad frame strobe.
module uart_rx_frame
  import uart_massiv_pkg::*;
#(
  parameter int CPB       = 4,
  parameter int PARITY    = PARITY_EVEN,
  parameter int N         = 5,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_line,
  output logic [N-1:0] frame_dat,
  output logic         frame_vld,
  output logic         frame_err
);

  localparam int CW = $clog2(CPB);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  // Counter restarts on the detect edge, so the start mid-point is one short of CPB/2.
  localparam logic [CW-1:0] START_MID = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_t     state;
  logic          line_q;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  shreg;
  logic          par_bit;
  logic          stop_cnt;
  logic          stop_bad;
  logic          exp_par;
  logic          par_err;

  always_comb begin
    exp_par = (PARITY == PARITY_ODD) ? ~(^shreg) : (^shreg);
    par_err = (PARITY != PARITY_NONE) && (par_bit != exp_par);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      line_q    <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop_cnt  <= 1'b0;
      stop_bad  <= 1'b0;
      frame_dat <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      line_q    <= rx_line;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (line_q && !rx_line) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == START_MID) begin
            cnt <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            if (rx_line) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= N'({rx_line, shreg} >> 1);
            if (bit_cnt == DATA_LAST) begin
              state    <= (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
              stop_cnt <= 1'b0;
              stop_bad <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_line;
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              frame_dat <= shreg;
              if (stop_bad || !rx_line || par_err) frame_err <= 1'b1;
              else                                 frame_vld <= 1'b1;
              state <= RX_IDLE;
            end else begin
              stop_cnt <= 1'b1;
              stop_bad <= stop_bad | ~rx_line;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_rx_massiv.sv
// Full-duplex UART endpoint: TX sends up to TD packs per launch, RX fills a buffer of RD packs.
// Latency: start bit on TX_PORT one cycle after the launch edge; RX counters one cycle after the frame strobe.
// Backpressure: none; launch edges while active are ignored, RX frames beyond RD are dropped.
// Ports: IN_CLOCK/IN_RESET (sync, active-high); TX: IN_TX_DATA_MASSIV, IN_TX_NUMBER_OF_PACKS_TO_SEND,
//        IN_TX_LAUNCH, OUT_TX_ACTIVE, OUT_TX_DONE, TX_PORT; RX: RX_PORT, IN_RX_CLEAR_BUFFER,
//        OUT_RX_DATA_MASSIV, OUT_RX_ERROR, OUT_RX_NUM_OF_DATA_PACKS_READY.
// Option: define UART_RX_SYNC_EN to put a 2-flop synchronizer on RX_PORT (adds 2 cycles of RX delay).
module uart_tx_rx_massiv
  import uart_massiv_pkg::*;
#(
  parameter int UART_BAUD_RATE           = 9600,
  parameter int CLOCK_FREQUENCY          = 38400,
  parameter int PARITY                   = PARITY_EVEN,
  parameter int NUM_OF_DATA_BITS_IN_PACK = 5,
  parameter int NUMBER_STOP_BITS         = 1,
  parameter int TX_MASSIV_DEEP           = 2,
  parameter int RX_MASSIV_DEEP           = 4
) (
  input  logic                                                IN_CLOCK,
  input  logic                                                IN_RESET,
  input  logic [NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP-1:0] IN_TX_DATA_MASSIV,
  input  logic [$clog2(TX_MASSIV_DEEP):0]                     IN_TX_NUMBER_OF_PACKS_TO_SEND,
  input  logic                                                IN_TX_LAUNCH,
  output logic                                                OUT_TX_ACTIVE,
  output logic                                                OUT_TX_DONE,
  input  logic                                                IN_RX_CLEAR_BUFFER,
  output logic [NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP-1:0] OUT_RX_DATA_MASSIV,
  output logic [$clog2(RX_MASSIV_DEEP):0]                     OUT_RX_ERROR,
  output logic [$clog2(RX_MASSIV_DEEP):0]                     OUT_RX_NUM_OF_DATA_PACKS_READY,
  output logic                                                TX_PORT,
  input  logic                                                RX_PORT
);

  localparam int N   = NUM_OF_DATA_BITS_IN_PACK;
  localparam int TD  = TX_MASSIV_DEEP;
  localparam int RD  = RX_MASSIV_DEEP;
  localparam int CPB = clks_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = (N > 1) ? $clog2(N) : 1;
  localparam int PW  = $clog2(TD) + 1;
  localparam int RW  = $clog2(RD) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);
  localparam logic          STOP_LAST = 1'(NUMBER_STOP_BITS - 1);
  localparam logic [PW-1:0] TD_CNT    = PW'(TD);
  localparam logic [RW-1:0] RD_CNT    = RW'(RD);

  // ---------------- TX serializer ----------------
  tx_state_t       tx_state;
  logic            launch_q;
  logic            launch_rise;
  logic [N*TD-1:0] tx_data_q;
  logic [PW-1:0]   pack_idx;
  logic [PW-1:0]   pack_total;
  logic [PW-1:0]   count_clamped;
  logic [CW-1:0]   clk_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            stop_cnt;
  logic [N-1:0]    tx_shift;
  logic [N-1:0]    cur_pack;
  logic            tx_par;
  logic            bit_end;
  logic            tx_port_r;
  logic            tx_active_r;
  logic            tx_done_r;

  assign launch_rise   = IN_TX_LAUNCH & ~launch_q;
  assign bit_end       = (clk_cnt == BIT_LAST);
  assign count_clamped = (IN_TX_NUMBER_OF_PACKS_TO_SEND > TD_CNT) ? TD_CNT : IN_TX_NUMBER_OF_PACKS_TO_SEND;

  always_comb begin
    cur_pack = '0;
    for (int k = 0; k < TD; k++) begin
      if (int'(pack_idx) == k) cur_pack = tx_data_q[k*N +: N];
    end
    tx_par = (PARITY == PARITY_ODD) ? ~(^cur_pack) : (^cur_pack);
  end

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      tx_state    <= TX_IDLE;
      launch_q    <= 1'b0;
      tx_data_q   <= '0;
      pack_idx    <= '0;
      pack_total  <= '0;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      tx_shift    <= '0;
      tx_port_r   <= 1'b1;
      tx_active_r <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      launch_q <= IN_TX_LAUNCH;
      case (tx_state)
        TX_IDLE: begin
          tx_port_r <= 1'b1;
          tx_done_r <= 1'b0;
          if (launch_rise) begin
            tx_data_q  <= IN_TX_DATA_MASSIV;
            pack_idx   <= '0;
            pack_total <= count_clamped;
            clk_cnt    <= '0;
            if (count_clamped == '0) begin
              tx_done_r <= 1'b1;
              tx_state  <= TX_DONE;
            end else begin
              tx_port_r   <= 1'b0;
              tx_active_r <= 1'b1;
              tx_state    <= TX_START;
            end
          end
        end
        TX_START: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            tx_port_r <= cur_pack[0];
            tx_shift  <= cur_pack >> 1;
            tx_state  <= TX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              stop_cnt <= 1'b0;
              if (PARITY == PARITY_NONE) begin
                tx_port_r <= 1'b1;
                tx_state  <= TX_STOP;
              end else begin
                tx_port_r <= tx_par;
                tx_state  <= TX_PARITY;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx_port_r <= tx_shift[0];
              tx_shift  <= tx_shift >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            tx_port_r <= 1'b1;
            tx_state  <= TX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= 1'b1;
            end else if ((pack_idx + 1'b1) < pack_total) begin
              // Next pack follows immediately with its start bit.
              pack_idx  <= pack_idx + 1'b1;
              tx_port_r <= 1'b0;
              tx_state  <= TX_START;
            end else begin
              tx_active_r <= 1'b0;
              tx_done_r   <= 1'b1;
              tx_state    <= TX_DONE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        TX_DONE: begin
          tx_done_r <= 1'b0;
          tx_state  <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign TX_PORT       = tx_port_r;
  assign OUT_TX_ACTIVE = tx_active_r;
  assign OUT_TX_DONE   = tx_done_r;

  // ---------------- RX path ----------------
  logic rx_line;
`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], RX_PORT};
  end
  assign rx_line = rx_sync[1];
`else
  assign rx_line = RX_PORT;
`endif

  logic [N-1:0] frame_dat;
  logic         frame_vld;
  logic         frame_err;

  uart_rx_frame #(
    .CPB       (CPB),
    .PARITY    (PARITY),
    .N         (N),
    .STOP_BITS (NUMBER_STOP_BITS)
  ) u_rx_frame (
    .clk       (IN_CLOCK),
    .rst       (IN_RESET),
    .rx_line   (rx_line),
    .frame_dat (frame_dat),
    .frame_vld (frame_vld),
    .frame_err (frame_err)
  );

  logic [N*RD-1:0] rx_buf;
  logic [RW-1:0]   rx_ready;
  logic [RW-1:0]   rx_err_cnt;

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET || IN_RX_CLEAR_BUFFER) begin
      // Clear takes priority; a frame completing in the same cycle is lost.
      rx_buf     <= '0;
      rx_ready   <= '0;
      rx_err_cnt <= '0;
    end else begin
      if (frame_vld && (rx_ready < RD_CNT)) begin
        for (int k = 0; k < RD; k++) begin
          if (int'(rx_ready) == k) rx_buf[k*N +: N] <= frame_dat;
        end
        rx_ready <= rx_ready + 1'b1;
      end
      if (frame_err && (rx_err_cnt < RD_CNT)) begin
        rx_err_cnt <= rx_err_cnt + 1'b1;
      end
    end
  end

  assign OUT_RX_DATA_MASSIV             = rx_buf;
  assign OUT_RX_ERROR                   = rx_err_cnt;
  assign OUT_RX_NUM_OF_DATA_PACKS_READY = rx_ready;

endmodule

// File: tb/tb_uart_tx_rx_massiv.sv
// Loopback bench: instance a transmits into instance b; b's RX can also be driven by hand-built frames.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_tx_rx_massiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  a_data;
  logic [1:0]  a_cnt;
  logic        a_launch;
  logic        a_tx, a_active, a_done;
  logic [19:0] a_rx_massiv;
  logic [2:0]  a_rx_err, a_rx_ready;
  logic        b_tx, b_active, b_done, b_clear;
  logic [19:0] b_rx_massiv;
  logic [2:0]  b_rx_err, b_rx_ready;
  logic        bb_sel, bb_line;
  logic        b_rx;

  assign b_rx = bb_sel ? bb_line : a_tx;

  uart_tx_rx_massiv u_a (
    .IN_CLOCK                       (clk),
    .IN_RESET                       (rst),
    .IN_TX_DATA_MASSIV              (a_data),
    .IN_TX_NUMBER_OF_PACKS_TO_SEND  (a_cnt),
    .IN_TX_LAUNCH                   (a_launch),
    .OUT_TX_ACTIVE                  (a_active),
    .OUT_TX_DONE                    (a_done),
    .IN_RX_CLEAR_BUFFER             (1'b0),
    .OUT_RX_DATA_MASSIV             (a_rx_massiv),
    .OUT_RX_ERROR                   (a_rx_err),
    .OUT_RX_NUM_OF_DATA_PACKS_READY (a_rx_ready),
    .TX_PORT                        (a_tx),
    .RX_PORT                        (b_tx)
  );

  uart_tx_rx_massiv u_b (
    .IN_CLOCK                       (clk),
    .IN_RESET                       (rst),
    .IN_TX_DATA_MASSIV              (10'd0),
    .IN_TX_NUMBER_OF_PACKS_TO_SEND  (2'd0),
    .IN_TX_LAUNCH                   (1'b0),
    .OUT_TX_ACTIVE                  (b_active),
    .OUT_TX_DONE                    (b_done),
    .IN_RX_CLEAR_BUFFER             (b_clear),
    .OUT_RX_DATA_MASSIV             (b_rx_massiv),
    .OUT_RX_ERROR                   (b_rx_err),
    .OUT_RX_NUM_OF_DATA_PACKS_READY (b_rx_ready),
    .TX_PORT                        (b_tx),
    .RX_PORT                        (b_rx)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        clr;
    logic [9:0]  data;
    logic [1:0]  cnt;
    int          exp_active;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_err;
    logic [19:0] exp_massiv;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_b();
    b_clear = 1'b1;
    repeat (2) @(negedge clk);
    b_clear = 1'b0;
    @(negedge clk);
  endtask

  // Raise launch, then follow the TX side until DONE; launch is left high for the caller.
  task automatic run_launch(input string tag, input logic [9:0] d, input logic [1:0] c, input int exp_act);
    int   act;
    bit   seen;
    logic first_tx;
    act      = 0;
    seen     = 1'b0;
    first_tx = 1'bx;
    a_data   = d;
    a_cnt    = c;
    a_launch = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0) first_tx = a_tx;
      if (a_done) begin
        seen = 1'b1;
        check({tag, "_active_at_done"}, 32'(a_active), 32'd0);
        break;
      end
      if (a_active) act++;
    end
    check({tag, "_first_tx"}, 32'(first_tx), (c == 2'd0) ? 32'd1 : 32'd0);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_active_cycles"}, 32'(act), 32'(exp_act));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(a_done), 32'd0);
  endtask

  task automatic send_bit(input logic b);
    bb_line = b;
    repeat (4) @(negedge clk);
  endtask

  task automatic bb_frame(input logic [4:0] d, input logic par, input logic stp);
    bb_sel = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    bb_line = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{1'b1, 10'b1001101010, 2'd2, 64, 3'd2, 3'd0, 20'h0026A};
    vecs[1] = '{1'b0, {5'h07, 5'h11}, 2'd2, 64, 3'd4, 3'd0, {5'h07, 5'h11, 5'h13, 5'h0A}};
    vecs[2] = '{1'b0, {5'h00, 5'h1F}, 2'd1, 32, 3'd4, 3'd0, {5'h07, 5'h11, 5'h13, 5'h0A}};
    vecs[3] = '{1'b1, {5'h1F, 5'h00}, 2'd3, 64, 3'd2, 3'd0, {10'd0, 5'h1F, 5'h00}};
    vecs[4] = '{1'b1, {5'h15, 5'h01}, 2'd1, 32, 3'd1, 3'd0, {15'd0, 5'h01}};

    rst      = 1'b1;
    a_data   = '0;
    a_cnt    = '0;
    a_launch = 1'b0;
    b_clear  = 1'b0;
    bb_sel   = 1'b0;
    bb_line  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_port", 32'(a_tx), 32'd1);
    check("rst_tx_active", 32'(a_active), 32'd0);
    check("rst_tx_done", 32'(a_done), 32'd0);
    check("rst_rx_ready", 32'(b_rx_ready), 32'd0);
    check("rst_rx_err", 32'(b_rx_err), 32'd0);
    check("rst_rx_massiv", 32'(b_rx_massiv), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of loopback launches.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].clr) clear_b();
      run_launch($sformatf("v%0d", i), vecs[i].data, vecs[i].cnt, vecs[i].exp_active);
      a_launch = 1'b0;
      repeat (10) @(negedge clk);
      check($sformatf("v%0d_ready", i), 32'(b_rx_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_err", i), 32'(b_rx_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_massiv", i), 32'(b_rx_massiv), 32'(vecs[i].exp_massiv));
    end

    // Launch held high after completion must not retransmit.
    run_launch("held", {5'h03, 5'h0C}, 2'd1, 32);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_active || !a_tx || a_done) bad++;
    end
    check("held_no_resend", 32'(bad), 32'd0);
    a_launch = 1'b0;
    repeat (2) @(negedge clk);

    // Count 0: nothing on the line, a single DONE pulse.
    run_launch("cnt0", {5'h1F, 5'h1F}, 2'd0, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_active || !a_tx || a_done) bad++;
    end
    check("cnt0_quiet", 32'(bad), 32'd0);
    a_launch = 1'b0;
    repeat (2) @(negedge clk);

    // Hand-built frames into b: bad parity, bad stop, start glitch, clear, then a good frame.
    clear_b();
    bb_frame(5'b01010, 1'b1, 1'b1);
    check("par_ready", 32'(b_rx_ready), 32'd0);
    check("par_err", 32'(b_rx_err), 32'd1);
    check("par_massiv", 32'(b_rx_massiv), 32'd0);
    bb_frame(5'b00110, 1'b0, 1'b0);
    check("stop_err", 32'(b_rx_err), 32'd2);
    check("stop_ready", 32'(b_rx_ready), 32'd0);
    bb_line = 1'b0;
    @(negedge clk);
    bb_line = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_err", 32'(b_rx_err), 32'd2);
    check("glitch_ready", 32'(b_rx_ready), 32'd0);
    clear_b();
    check("clr_ready", 32'(b_rx_ready), 32'd0);
    check("clr_err", 32'(b_rx_err), 32'd0);
    check("clr_massiv", 32'(b_rx_massiv), 32'd0);
    bb_frame(5'b10110, 1'b1, 1'b1);
    check("after_clr_ready", 32'(b_rx_ready), 32'd1);
    check("after_clr_massiv", 32'(b_rx_massiv), 32'h00016);
    check("after_clr_err", 32'(b_rx_err), 32'd0);
    bb_sel = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame.
    a_data   = {5'h0F, 5'h15};
    a_cnt    = 2'd2;
    a_launch = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_active", 32'(a_active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_port", 32'(a_tx), 32'd1);
    check("mid_rst_active", 32'(a_active), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    a_launch = 1'b0;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (a_active || !a_tx || a_done) bad++;
    end
    check("mid_rst_line_idle", 32'(bad), 32'd0);
    check("mid_rst_rx_ready", 32'(b_rx_ready), 32'd0);
    check("mid_rst_rx_err", 32'(b_rx_err), 32'd0);
    check("a_rx_idle_ready", 32'(a_rx_ready), 32'd0);
    check("a_rx_idle_err", 32'(a_rx_err), 32'd0);
    check("a_rx_idle_massiv", 32'(a_rx_massiv), 32'd0);
    check("b_tx_idle", {30'd0, b_active | b_done, b_tx}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
